// File: rtl/pwm_shadow_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_shadow_gen
// Brief    : PWM generator with a one-deep shadow duty register. New duty is
//            applied only on a period boundary or while disabled.
// Revision : 1.0
// ============================================================================
module pwm_shadow_gen #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter bit INVERT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    input  logic             enable,
    output logic             pwm_out,
    output logic             period_start,
    output logic [WIDTH-1:0] active_duty
);

    localparam int               c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] c_max      = '1;
    localparam logic [WIDTH-1:0] c_last_cnt = c_max - WIDTH'(1);

    logic [c_pre_w-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic               pending_full_q, pending_full_d;
    logic [WIDTH-1:0]   active_duty_q, active_duty_d;
    logic               pwm_q, pwm_d;
    logic               period_start_q, period_start_d;

    logic w_tick;
    logic w_boundary;
    logic w_accept;

    assign w_tick     = enable && (pre_cnt_q == c_pre_last);
    assign w_boundary = w_tick && (cnt_q == c_last_cnt);
    assign w_accept   = duty_valid && !pending_full_q;

    always_comb begin
        pre_cnt_d      = pre_cnt_q;
        cnt_d          = cnt_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_duty_d  = active_duty_q;

        if (!enable) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
        end else begin
            pre_cnt_d = (pre_cnt_q == c_pre_last) ? '0 : pre_cnt_q + c_pre_w'(1);
            if (w_tick) begin
                cnt_d = (cnt_q == c_last_cnt) ? '0 : cnt_q + WIDTH'(1);
            end
        end

        // Accept only happens with the shadow empty, so a word taken on a
        // boundary cycle is never applied at that same boundary.
        if (w_accept) begin
            pending_d      = duty_in;
            pending_full_d = 1'b1;
        end else if (pending_full_q && (!enable || w_boundary)) begin
            active_duty_d  = pending_q;
            pending_full_d = 1'b0;
        end

        pwm_d          = (enable && (cnt_q < active_duty_q)) ^ INVERT;
        period_start_d = enable && (pre_cnt_q == '0) && (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            cnt_q          <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_duty_q  <= '0;
            pwm_q          <= INVERT;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_duty_q  <= active_duty_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign duty_ready   = !pending_full_q;
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign active_duty  = active_duty_q;

endmodule
`default_nettype wire
